// File: rtl/mipi_lane_merge.sv
// rtl/mipi_lane_merge.sv - CSI-2 lane deskew FIFOs and packet parser producing payload words
module mipi_lane_merge #(
    parameter int LANES      = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int SKEW_MAX   = 6
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [LANES*8-1:0] byte_data,
    input  logic [LANES-1:0]   byte_valid,
    output logic [LANES*8-1:0] data_out,
    output logic [LANES-1:0]   data_be,
    output logic               data_valid,
    output logic               data_last,
    output logic [5:0]         data_type,
    output logic               data_vsync,
    output logic               packet_done,
    output logic               skew_err,
    output logic               ovf_err
);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int SW       = $clog2(SKEW_MAX + 1);
    localparam int HDR_POPS = 4 / LANES;
    localparam int HW       = (HDR_POPS > 1) ? $clog2(HDR_POPS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_HEADER, S_PAYLOAD, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_mem  [LANES][FIFO_DEPTH];
    logic [AW:0]        r_wptr [LANES];
    logic [AW:0]        r_rptr [LANES];
    logic [SW-1:0]      r_skew_cnt;
    logic [HW-1:0]      r_hdr_cnt;
    logic [23:0]        r_hdr;
    logic [15:0]        r_rem;
    logic [LANES*8-1:0] r_data_out;
    logic [LANES-1:0]   r_data_be;
    logic               r_data_valid;
    logic               r_data_last;
    logic [5:0]         r_data_type;
    logic               r_data_vsync;
    logic               r_skew_err;
    logic               r_ovf_err;

    logic [LANES-1:0]   w_empty;
    logic [LANES-1:0]   w_full;
    logic [LANES-1:0]   w_wr;
    logic [LANES-1:0]   w_drop;
    logic [LANES*8-1:0] w_head;
    logic [LANES*8-1:0] w_word;
    logic [LANES-1:0]   w_be;
    logic [23:0]        w_hdr;
    logic [SW-1:0]      w_skew_inc;
    logic               w_avail;
    logic               w_pop;
    logic               w_flush;
    logic               w_hdr_last;
    logic               w_last;

    // Full/empty share the low pointer bits; the extra MSB tells them apart.
    always_comb begin
        w_empty = '0;
        w_full  = '0;
        w_head  = '0;
        for (int k = 0; k < LANES; k++) begin
            w_empty[k]       = (r_wptr[k] == r_rptr[k]);
            w_full[k]        = (r_wptr[k][AW] != r_rptr[k][AW]) &&
                               (r_wptr[k][AW-1:0] == r_rptr[k][AW-1:0]);
            w_head[8*k +: 8] = r_mem[k][r_rptr[k][AW-1:0]];
        end
    end

    assign w_avail    = ~|w_empty;
    assign w_skew_inc = r_skew_cnt + SW'(1);
    assign w_hdr_last = (r_hdr_cnt == HW'(HDR_POPS - 1));
    assign w_last     = (r_rem <= 16'(LANES));

    // Header bytes land in lane order; the ECC byte is never kept.
    always_comb begin
        w_hdr = r_hdr;
        for (int k = 0; k < LANES; k++) begin
            if (int'(r_hdr_cnt) * LANES + k < 3)
                w_hdr[8*(int'(r_hdr_cnt) * LANES + k) +: 8] = w_head[8*k +: 8];
        end
    end

    always_comb begin
        w_be   = '0;
        w_word = '0;
        for (int k = 0; k < LANES; k++) begin
            w_be[k]          = (r_rem > 16'(k));
            w_word[8*k +: 8] = w_be[k] ? w_head[8*k +: 8] : 8'h00;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|(~w_empty))
                    w_state_nxt = S_ALIGN;
            end
            S_ALIGN: begin
                if (w_avail)
                    w_state_nxt = S_HEADER;
                else if (w_skew_inc == SW'(SKEW_MAX))
                    w_state_nxt = S_DONE;
            end
            S_HEADER: begin
                if (w_avail) begin
                    w_pop = 1'b1;
                    if (w_hdr_last) begin
                        if (w_hdr[5:0] <= 6'h0F || w_hdr[23:8] == 16'h0000)
                            w_state_nxt = S_DONE;
                        else
                            w_state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_avail) begin
                    w_pop = 1'b1;
                    if (w_last)
                        w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_flush     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A pop frees a slot in the same cycle, so a full FIFO may still accept.
    always_comb begin
        w_wr   = '0;
        w_drop = '0;
        for (int k = 0; k < LANES; k++) begin
            w_wr[k]   = byte_valid[k] && !w_flush && (!w_full[k] || w_pop);
            w_drop[k] = byte_valid[k] && !w_flush && w_full[k] && !w_pop;
        end
    end

    always_ff @(posedge sys_clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (!sys_rst && w_wr[k])
                r_mem[k][r_wptr[k][AW-1:0]] <= byte_data[8*k +: 8];
        end
    end

    always_ff @(posedge sys_clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (sys_rst) begin
                r_wptr[k] <= '0;
                r_rptr[k] <= '0;
            end else if (w_flush) begin
                r_rptr[k] <= r_wptr[k];
            end else begin
                if (w_wr[k])
                    r_wptr[k] <= r_wptr[k] + 1'b1;
                if (w_pop)
                    r_rptr[k] <= r_rptr[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= S_IDLE;
            r_skew_cnt   <= '0;
            r_hdr_cnt    <= '0;
            r_hdr        <= '0;
            r_rem        <= '0;
            r_data_out   <= '0;
            r_data_be    <= '0;
            r_data_valid <= 1'b0;
            r_data_last  <= 1'b0;
            r_data_type  <= '0;
            r_data_vsync <= 1'b0;
            r_skew_err   <= 1'b0;
            r_ovf_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_data_valid <= 1'b0;
            r_data_last  <= 1'b0;
            r_skew_err   <= 1'b0;
            r_ovf_err    <= |w_drop;
            case (r_state)
                S_IDLE: begin
                    r_skew_cnt <= '0;
                    r_hdr_cnt  <= '0;
                end
                S_ALIGN: begin
                    if (!w_avail) begin
                        r_skew_cnt <= w_skew_inc;
                        if (w_skew_inc == SW'(SKEW_MAX))
                            r_skew_err <= 1'b1;
                    end
                end
                S_HEADER: begin
                    if (w_avail) begin
                        r_hdr <= w_hdr;
                        if (w_hdr_last) begin
                            r_hdr_cnt   <= '0;
                            r_data_type <= w_hdr[5:0];
                            r_rem       <= w_hdr[23:8];
                            if (w_hdr[5:0] == 6'h00)
                                r_data_vsync <= 1'b1;
                            else if (w_hdr[5:0] == 6'h01)
                                r_data_vsync <= 1'b0;
                        end else begin
                            r_hdr_cnt <= r_hdr_cnt + 1'b1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_avail) begin
                        r_data_out   <= w_word;
                        r_data_be    <= w_be;
                        r_data_valid <= 1'b1;
                        r_data_last  <= w_last;
                        r_rem        <= r_rem - 16'(LANES);
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign data_be     = r_data_be;
    assign data_valid  = r_data_valid;
    assign data_last   = r_data_last;
    assign data_type   = r_data_type;
    assign data_vsync  = r_data_vsync;
    assign packet_done = (r_state == S_DONE);
    assign skew_err    = r_skew_err;
    assign ovf_err     = r_ovf_err;
endmodule

// File: tb/tb_mipi_lane_merge.sv
// tb/tb_mipi_lane_merge.sv - scoreboard bench for mipi_lane_merge with LANES=2
module tb_mipi_lane_merge;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] byte_data;
    logic [1:0]  byte_valid;
    logic [15:0] data_out;
    logic [1:0]  data_be;
    logic        data_valid;
    logic        data_last;
    logic [5:0]  data_type;
    logic        data_vsync;
    logic        packet_done;
    logic        skew_err;
    logic        ovf_err;

    always #5 clk = ~clk;

    mipi_lane_merge #(.LANES(2), .FIFO_DEPTH(8), .SKEW_MAX(6)) dut (
        .sys_clk(clk), .sys_rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
        .data_out(data_out), .data_be(data_be), .data_valid(data_valid), .data_last(data_last),
        .data_type(data_type), .data_vsync(data_vsync), .packet_done(packet_done),
        .skew_err(skew_err), .ovf_err(ovf_err)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  be;
        logic        last;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] q_pkt[$];
    logic [7:0] q_l0[$];
    logic [7:0] q_l1[$];
    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_done = 0;
    int n_skew = 0;
    int n_ovf = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (data_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual data_out=%0h required no data_valid", data_out);
            end else begin
                e = exp_q.pop_front();
                check("word_data", {16'h0, data_out}, {16'h0, e.d});
                check("word_be", {30'h0, data_be}, {30'h0, e.be});
                check("word_last", {31'h0, data_last}, {31'h0, e.last});
            end
        end
        if (packet_done) n_done++;
        if (skew_err)    n_skew++;
        if (ovf_err)     n_ovf++;
    end

    task automatic split_pkt();
        q_l0 = {};
        q_l1 = {};
        foreach (q_pkt[i]) begin
            if (i % 2 == 0) q_l0.push_back(q_pkt[i]);
            else            q_l1.push_back(q_pkt[i]);
        end
    endtask

    task automatic drive(input int lag);
        int n0 = q_l0.size();
        int n1 = q_l1.size();
        int total = (n0 > lag + n1) ? n0 : lag + n1;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            byte_valid = 2'b00;
            byte_data  = 16'h0000;
            if (c < n0) begin
                byte_valid[0]   = 1'b1;
                byte_data[7:0]  = q_l0[c];
            end
            if (c >= lag && c - lag < n1) begin
                byte_valid[1]   = 1'b1;
                byte_data[15:8] = q_l1[c - lag];
            end
        end
        @(negedge clk);
        byte_valid = 2'b00;
        byte_data  = 16'h0000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_done(input string name, input int prev);
        int k = 0;
        while (n_done == prev && k < 80) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (n_done == prev) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual no packet_done required packet_done", name);
        end
        idle(3);
    endtask

    task automatic push_long_words();
        exp_q.push_back('{d: 16'h1211, be: 2'b11, last: 1'b0});
        exp_q.push_back('{d: 16'h1413, be: 2'b11, last: 1'b0});
        exp_q.push_back('{d: 16'h0015, be: 2'b01, last: 1'b1});
    endtask

    initial begin
        int pd0, sk0, ov0, v0, k;
        rst        = 1'b1;
        byte_valid = 2'b00;
        byte_data  = 16'h0000;
        idle(3);
        check("rst_data", {14'h0, data_be, data_out}, 32'h0);
        check("rst_flags", {25'h0, data_valid, data_last, packet_done, skew_err, ovf_err, data_vsync, 1'b0},
              32'h0);
        check("rst_type", {26'h0, data_type}, 32'h0);
        rst = 1'b0;
        idle(2);

        // frame start short packet
        pd0 = n_done;
        q_pkt = '{8'h00, 8'h00, 8'h00, 8'h5A};
        split_pkt();
        drive(0);
        wait_done("fs", pd0);
        check("fs_vsync", {31'h0, data_vsync}, 32'h1);
        check("fs_done_once", n_done, pd0 + 1);
        check("fs_no_valid", n_valid, 0);

        // long packet, lanes aligned
        pd0 = n_done;
        sk0 = n_skew;
        push_long_words();
        q_pkt = '{8'h2A, 8'h05, 8'h00, 8'h3C, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'hC0, 8'hC1};
        split_pkt();
        drive(0);
        wait_done("long", pd0);
        check("long_words_seen", exp_q.size(), 0);
        check("long_type", {26'h0, data_type}, 32'h2A);
        check("long_done_once", n_done, pd0 + 1);
        check("long_hold_data", {16'h0, data_out}, 32'h0015);
        check("long_hold_be", {30'h0, data_be}, 32'h1);
        check("long_vsync", {31'h0, data_vsync}, 32'h1);

        // lane 1 lagging 3 cycles
        pd0 = n_done;
        push_long_words();
        drive(3);
        wait_done("lag3", pd0);
        check("lag3_words_seen", exp_q.size(), 0);
        check("lag3_no_skew", n_skew, sk0);
        check("lag3_done_once", n_done, pd0 + 1);

        // lane 1 lagging 7 cycles
        pd0 = n_done;
        v0  = n_valid;
        q_l0 = '{8'h77};
        q_l1 = '{8'h88};
        drive(7);
        wait_done("lag7", pd0);
        idle(10);
        check("lag7_skew", n_skew, sk0 + 1);
        check("lag7_done", n_done, pd0 + 1);
        check("lag7_no_valid", n_valid, v0);

        // lane 1 stalled mid-payload, lane 0 overflows on its 9th byte
        pd0 = n_done;
        ov0 = n_ovf;
        q_l0 = '{8'h2B, 8'h00};
        q_l1 = '{8'h10, 8'h5A};
        drive(0);
        idle(4);
        check("ovf_none_yet", n_ovf, ov0);
        q_l0 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
        q_l1 = {};
        drive(0);
        idle(2);
        check("ovf_pulse", n_ovf, ov0 + 1);
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{d: {8'hB1 + 8'(i), 8'hA1 + 8'(i)}, be: 2'b11, last: (i == 7)});
        q_l0 = {};
        q_l1 = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8};
        drive(0);
        wait_done("ovf", pd0);
        check("ovf_words_seen", exp_q.size(), 0);
        check("ovf_once", n_ovf, ov0 + 1);
        check("ovf_type", {26'h0, data_type}, 32'h2B);

        // reset right after the second payload word
        pd0 = n_done;
        v0  = n_valid;
        exp_q.push_back('{d: 16'h1211, be: 2'b11, last: 1'b0});
        exp_q.push_back('{d: 16'h1413, be: 2'b11, last: 1'b0});
        q_pkt = '{8'h2A, 8'h05, 8'h00, 8'h3C, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'hC0, 8'hC1};
        split_pkt();
        drive(0);
        k = 0;
        while (n_valid < v0 + 2 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("rstmid_second_word", n_valid, v0 + 2);
        rst        = 1'b1;
        byte_valid = 2'b11;
        byte_data  = 16'h0101;
        @(negedge clk);
        check("rstmid_data", {14'h0, data_be, data_out}, 32'h0);
        check("rstmid_flags", {26'h0, data_valid, data_last, packet_done, skew_err, ovf_err, data_vsync},
              32'h0);
        check("rstmid_type", {26'h0, data_type}, 32'h0);
        rst        = 1'b0;
        byte_valid = 2'b00;
        byte_data  = 16'h0000;
        idle(12);
        check("rstmid_no_done", n_done, pd0);
        check("rstmid_no_more_words", n_valid, v0 + 2);

        // frame start then frame end after the reset
        q_pkt = '{8'h00, 8'h00, 8'h00, 8'h11};
        split_pkt();
        drive(0);
        wait_done("fs2", pd0);
        check("fs2_vsync", {31'h0, data_vsync}, 32'h1);
        pd0 = n_done;
        q_pkt = '{8'h01, 8'h00, 8'h00, 8'h22};
        split_pkt();
        drive(0);
        wait_done("fe", pd0);
        check("fe_vsync", {31'h0, data_vsync}, 32'h0);
        check("fe_type", {26'h0, data_type}, 32'h01);
        check("fe_done_once", n_done, pd0 + 1);
        check("fe_no_valid", n_valid, v0 + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
